// File: rtl/ctrl_unit_seq.sv
// Control sequencer for the 18-bit core: fetch/decode/execute/mem/write-back,
// interrupt entry with bounded nesting, and a per-transaction bus watchdog.
module ctrl_unit_seq #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned NEST_DEPTH = 4,
  localparam int unsigned NW        = $clog2(NEST_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          int_req_i,
  input  logic [6:0]    op_i,
  input  logic [2:0]    func_i,
  input  logic          inst_ack_i,
  input  logic          data_ack_i,
  input  logic          port_ack_i,
  output logic          inst_cyc_o,
  output logic          data_cyc_o,
  output logic          data_we_o,
  output logic          port_cyc_o,
  output logic          port_we_o,
  output logic          pc_en_o,
  output logic [1:0]    pc_op_o,
  output logic          push_o,
  output logic          pop_o,
  output logic          alu_en_o,
  output logic          reg_wr_o,
  output logic          int_ack_o,
  output logic          ie_o,
  output logic [NW-1:0] nest_o,
  output logic          bus_err_o,
  output logic [2:0]    state_o
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_INT       = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t        r_state, w_next;
  logic          r_ie;
  logic [NW-1:0] r_nest;
  logic [WW-1:0] r_wd, w_wd_next;

  logic w_mem, w_alu, w_jump, w_branch, w_misc;
  logic w_ret, w_reti, w_enai, w_disi, w_halt;
  logic w_data_bus, w_port_bus, w_bus_ack, w_pend, w_timeout;

  assign w_mem    = (op_i[6:5] == 2'b10);
  assign w_alu    = ~op_i[6] | (op_i[6:4] == 3'b110) | (op_i[6:3] == 4'b1110);
  assign w_jump   = (op_i[6:2] == 5'b11110);
  assign w_branch = (op_i[6:1] == 6'b111110);
  assign w_misc   = (op_i == 7'b1111110);

  assign w_ret  = w_misc & (func_i == 3'b000);
  assign w_reti = w_misc & (func_i == 3'b001);
  assign w_enai = w_misc & (func_i == 3'b010);
  assign w_disi = w_misc & (func_i == 3'b011);
  assign w_halt = w_misc & (func_i[2:1] == 2'b10);

  assign w_data_bus = w_mem & ~func_i[1];
  assign w_port_bus = w_mem &  func_i[1];
  assign w_bus_ack  = w_data_bus ? data_ack_i : port_ack_i;

  assign w_pend    = int_req_i & r_ie & (r_nest < NW'(NEST_DEPTH));
  assign w_timeout = (r_wd == WW'(TIMEOUT - 1));

  assign ie_o    = r_ie;
  assign nest_o  = r_nest;
  assign state_o = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_wd    <= '0;
    end else begin
      r_state <= w_next;
      r_wd    <= w_wd_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ie   <= 1'b0;
      r_nest <= '0;
    end else if (r_state == S_DECODE) begin
      if (w_enai | w_reti) r_ie <= 1'b1;
      if (w_disi)          r_ie <= 1'b0;
      if (w_reti && r_nest != '0) r_nest <= r_nest - NW'(1);
    end else if (r_state == S_INT) begin
      r_ie <= 1'b0;
      if (r_nest < NW'(NEST_DEPTH)) r_nest <= r_nest + NW'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wd_next  = '0;
    inst_cyc_o = 1'b0;
    data_cyc_o = 1'b0;
    data_we_o  = 1'b0;
    port_cyc_o = 1'b0;
    port_we_o  = 1'b0;
    pc_en_o    = 1'b0;
    pc_op_o    = 2'b00;
    push_o     = 1'b0;
    pop_o      = 1'b0;
    alu_en_o   = 1'b0;
    reg_wr_o   = 1'b0;
    int_ack_o  = 1'b0;
    bus_err_o  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        inst_cyc_o = 1'b1;
        if (inst_ack_i)     w_next = S_DECODE;
        else if (w_timeout) w_next = S_ERROR;
        else                w_wd_next = r_wd + WW'(1);
      end
      S_DECODE: begin
        if (w_halt) begin
          // PC advances only on the wake-up cycle so the return address skips the halt
          if (w_pend) begin
            pc_en_o = 1'b1;
            w_next  = S_INT;
          end
        end else if (w_alu | w_mem) begin
          pc_en_o = 1'b1;
          w_next  = S_EXECUTE;
        end else begin
          pc_en_o = 1'b1;
          if (w_jump)               pc_op_o = 2'b01;
          else if (w_branch)        pc_op_o = 2'b11;
          else if (w_ret | w_reti)  pc_op_o = 2'b10;
          push_o = w_jump & func_i[0];
          pop_o  = w_ret | w_reti;
          // enai/reti change ie/nest at this edge; the new state is not sampled here
          w_next = (w_pend & ~(w_enai | w_reti)) ? S_INT : S_FETCH;
        end
      end
      S_EXECUTE, S_MEM: begin
        if (w_mem) begin
          data_cyc_o = w_data_bus;
          data_we_o  = w_data_bus & func_i[0];
          port_cyc_o = w_port_bus;
          port_we_o  = w_port_bus & func_i[0];
          if (w_bus_ack) begin
            if (func_i[0]) w_next = w_pend ? S_INT : S_FETCH;
            else           w_next = S_WRITEBACK;
          end else if (w_timeout) begin
            w_next = S_ERROR;
          end else begin
            w_next    = S_MEM;
            w_wd_next = r_wd + WW'(1);
          end
        end else begin
          alu_en_o = (r_state == S_EXECUTE);
          w_next   = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        reg_wr_o = 1'b1;
        w_next   = w_pend ? S_INT : S_FETCH;
      end
      S_INT: begin
        int_ack_o = 1'b1;
        push_o    = 1'b1;
        w_next    = S_FETCH;
      end
      S_ERROR: begin
        bus_err_o = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Scoreboard bench for ctrl_unit_seq: per-instruction reference traces are queued
// ahead of time and a monitor compares one record per clock.
module tb_ctrl_unit_seq;
  localparam int unsigned T  = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned NW = $clog2(D + 1);

  localparam logic [6:0] MISC = 7'b1111110;

  localparam logic [13:0] O_INST = 14'h2000, O_DCYC = 14'h1000, O_DWE  = 14'h0800,
                          O_PCYC = 14'h0400, O_PWE  = 14'h0200, O_PCEN = 14'h0100,
                          O_OPJ  = 14'h0040, O_OPR  = 14'h0080, O_OPB  = 14'h00C0,
                          O_PUSH = 14'h0020, O_POP  = 14'h0010, O_ALU  = 14'h0008,
                          O_RWR  = 14'h0004, O_IACK = 14'h0002, O_BERR = 14'h0001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic int_req_i, inst_ack_i, data_ack_i, port_ack_i;
  logic [6:0] op_i;
  logic [2:0] func_i;
  logic inst_cyc_o, data_cyc_o, data_we_o, port_cyc_o, port_we_o, pc_en_o;
  logic [1:0] pc_op_o;
  logic push_o, pop_o, alu_en_o, reg_wr_o, int_ack_o, ie_o, bus_err_o;
  logic [NW-1:0] nest_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  ctrl_unit_seq #(.TIMEOUT(T), .NEST_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .int_req_i(int_req_i), .op_i(op_i), .func_i(func_i),
    .inst_ack_i(inst_ack_i), .data_ack_i(data_ack_i), .port_ack_i(port_ack_i),
    .inst_cyc_o(inst_cyc_o), .data_cyc_o(data_cyc_o), .data_we_o(data_we_o),
    .port_cyc_o(port_cyc_o), .port_we_o(port_we_o), .pc_en_o(pc_en_o),
    .pc_op_o(pc_op_o), .push_o(push_o), .pop_o(pop_o), .alu_en_o(alu_en_o),
    .reg_wr_o(reg_wr_o), .int_ack_o(int_ack_o), .ie_o(ie_o), .nest_o(nest_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  typedef struct packed {
    logic [2:0]    st;
    logic [13:0]   o;
    logic          ie;
    logic [NW-1:0] nest;
  } exp_t;

  typedef struct packed {
    logic irq, ia, da, pa;
  } drv_t;

  exp_t exp_q[$];
  drv_t drv_q[$];
  exp_t mon_e;
  int unsigned total = 0;
  int unsigned bad   = 0;
  bit mon_en = 1'b0;

  bit          m_ie;
  int unsigned m_nest;

  logic [13:0] obs;
  assign obs = {inst_cyc_o, data_cyc_o, data_we_o, port_cyc_o, port_we_o, pc_en_o,
                pc_op_o, push_o, pop_o, alu_en_o, reg_wr_o, int_ack_o, bus_err_o};

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ({state_o, obs, ie_o, nest_o} !== {3'd0, O_INST, 1'b0, NW'(0)}) begin
        bad++;
        $display("FAIL reset: state=%0d out=%b ie=%b nest=%0d want state=0 out=%b ie=0 nest=0",
                 state_o, obs, ie_o, nest_o, O_INST);
      end
    end else if (mon_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL underflow: state=%0d out=%b with no expected record", state_o, obs);
      end else begin
        mon_e = exp_q.pop_front();
        total++;
        if ({state_o, obs, ie_o, nest_o} !== mon_e) begin
          bad++;
          $display("FAIL trace @%0t: state=%0d out=%b ie=%b nest=%0d want state=%0d out=%b ie=%b nest=%0d",
                   $time, state_o, obs, ie_o, nest_o, mon_e.st, mon_e.o, mon_e.ie, mon_e.nest);
        end
      end
    end
  end

  function automatic bit pend(input bit irq);
    return irq && m_ie && (m_nest < D);
  endfunction

  task automatic add(input logic [2:0] st, input logic [13:0] o,
                     input logic irq, input logic ia, input logic da, input logic pa);
    exp_t e;
    drv_t d;
    e.st = st; e.o = o; e.ie = m_ie; e.nest = NW'(m_nest);
    d.irq = irq; d.ia = ia; d.da = da; d.pa = pa;
    exp_q.push_back(e);
    drv_q.push_back(d);
  endtask

  task automatic take_int(input bit irq);
    add(3'd5, O_IACK | O_PUSH, irq, 1'b0, 1'b0, 1'b0);
    m_ie = 1'b0;
    m_nest++;
  endtask

  // Builds the expected trace of one instruction, then plays its input plan.
  // fd/bd: no-ack cycles before inst/bus ack (>= T means never), w: halt stall,
  // cut: if nonzero, only the first cut cycles are played.
  task automatic issue(input logic [6:0] op, input logic [2:0] fn, input bit irq_in,
                       input int unsigned fd, input int unsigned bd,
                       input int unsigned w, input int unsigned cut);
    bit irq, p, port, we;
    logic [13:0] o, bo;
    drv_t d;
    irq = irq_in;
    if (op == MISC && fn[2:1] == 2'b10 && !(m_ie && m_nest < D)) fn = 3'b010;
    op_i = op;
    func_i = fn;
    for (int unsigned i = 0; i < fd && i < T; i++) add(3'd0, O_INST, irq, 1'b0, 1'b0, 1'b0);
    if (fd >= T) begin
      repeat (5) add(3'd6, O_BERR, 1'b1, 1'b1, 1'b1, 1'b1);
    end else begin
      add(3'd0, O_INST, irq, 1'b1, 1'b0, 1'b0);
      if (!op[6] || op[6:4] == 3'b110 || op[6:3] == 4'b1110) begin
        add(3'd1, O_PCEN, irq, 1'b0, 1'b0, 1'b0);
        add(3'd2, O_ALU, irq, 1'b0, 1'b0, 1'b0);
        add(3'd4, O_RWR, irq, 1'b0, 1'b0, 1'b0);
        if (pend(irq)) take_int(irq);
      end else if (op[6:5] == 2'b10) begin
        port = fn[1];
        we = fn[0];
        bo = port ? (O_PCYC | (we ? O_PWE : 14'h0)) : (O_DCYC | (we ? O_DWE : 14'h0));
        add(3'd1, O_PCEN, irq, 1'b0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < bd && i < T; i++)
          add((i == 0) ? 3'd2 : 3'd3, bo, irq, 1'b0, 1'b0, 1'b0);
        if (bd >= T) begin
          repeat (5) add(3'd6, O_BERR, 1'b1, 1'b1, 1'b1, 1'b1);
        end else begin
          add((bd == 0) ? 3'd2 : 3'd3, bo, irq, 1'b0, !port, port);
          if (!we) add(3'd4, O_RWR, irq, 1'b0, 1'b0, 1'b0);
          if (pend(irq)) take_int(irq);
        end
      end else if (op == MISC && fn[2:1] == 2'b10) begin
        if (!pend(irq)) begin
          repeat (w) add(3'd1, 14'h0, 1'b0, 1'b0, 1'b0, 1'b0);
          irq = 1'b1;
        end
        add(3'd1, O_PCEN, irq, 1'b0, 1'b0, 1'b0);
        take_int(irq);
      end else begin
        o = O_PCEN;
        if (op[6:2] == 5'b11110) o = o | O_OPJ | (fn[0] ? O_PUSH : 14'h0);
        else if (op[6:1] == 6'b111110) o = o | O_OPB;
        else if (fn == 3'b000 || fn == 3'b001) o = o | O_OPR | O_POP;
        p = pend(irq) && !(op == MISC && (fn == 3'b001 || fn == 3'b010));
        add(3'd1, o, irq, 1'b0, 1'b0, 1'b0);
        if (op == MISC) begin
          case (fn)
            3'b001: begin m_ie = 1'b1; if (m_nest > 0) m_nest--; end
            3'b010: m_ie = 1'b1;
            3'b011: m_ie = 1'b0;
            default: ;
          endcase
        end
        if (p) take_int(irq);
      end
    end
    if (cut > 0) begin
      while (drv_q.size() > cut) begin
        void'(drv_q.pop_back());
        void'(exp_q.pop_back());
      end
    end
    while (drv_q.size() > 0) begin
      d = drv_q.pop_front();
      {int_req_i, inst_ack_i, data_ack_i, port_ack_i} = {d.irq, d.ia, d.da, d.pa};
      @(posedge clk);
      #1;
    end
  endtask

  // Reset lands between edges so the monitor sees it before any clock edge.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    mon_en = 1'b0;
    {int_req_i, inst_ack_i, data_ack_i, port_ack_i} = 4'b1111;
    m_ie = 1'b0;
    m_nest = 0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    {int_req_i, inst_ack_i, data_ack_i, port_ack_i} = 4'b0000;
    rst = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [6:0] op;
    logic [2:0] fn;
    logic [2:0] misc_fn [7];
    int unsigned cls;
    misc_fn = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5};
    {int_req_i, inst_ack_i, data_ack_i, port_ack_i} = 4'b0000;
    op_i = '0;
    func_i = '0;
    m_ie = 1'b0;
    m_nest = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    issue(7'h05, 3'd0, 1'b0, 0, 0, 0, 0);
    issue(7'b1000000, 3'b000, 1'b0, 1, 3, 0, 0);
    issue(7'b1011010, 3'b011, 1'b0, 0, 0, 0, 0);
    issue(MISC, 3'b010, 1'b1, 0, 0, 0, 0);
    issue(7'h11, 3'd0, 1'b1, 0, 0, 0, 0);
    issue(MISC, 3'b010, 1'b1, 0, 0, 0, 0);
    issue(7'b1101010, 3'd2, 1'b1, 0, 0, 0, 0);
    issue(MISC, 3'b010, 1'b1, 0, 0, 0, 0);
    issue(7'b1110101, 3'd0, 1'b1, 0, 0, 0, 0);
    issue(MISC, 3'b001, 1'b1, 0, 0, 0, 0);
    issue(7'h22, 3'd0, 1'b1, 0, 0, 0, 0);
    issue(MISC, 3'b001, 1'b0, 0, 0, 0, 0);
    issue(MISC, 3'b100, 1'b0, 0, 0, 10, 0);
    issue(MISC, 3'b001, 1'b0, 0, 0, 0, 0);
    issue(MISC, 3'b001, 1'b0, 0, 0, 0, 0);
    issue(7'b1111000, 3'b001, 1'b0, 0, 0, 0, 0);
    issue(7'b1111100, 3'b000, 1'b0, 0, 0, 0, 0);
    issue(MISC, 3'b000, 1'b0, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      cls = $urandom_range(0, 9);
      fn = 3'($urandom);
      case (cls)
        0, 1: op = {1'b0, 6'($urandom)};
        2, 3: op = {2'b10, 5'($urandom)};
        4:    op = {3'b110, 4'($urandom)};
        5:    op = {4'b1110, 3'($urandom)};
        6:    op = {5'b11110, 2'($urandom)};
        7:    op = {6'b111110, 1'($urandom)};
        default: begin
          op = MISC;
          fn = misc_fn[$urandom_range(0, 6)];
        end
      endcase
      issue(op, fn, ($urandom_range(0, 2) == 0), $urandom_range(0, T - 1),
            $urandom_range(0, T - 1), $urandom_range(0, 6), 0);
    end

    issue(7'b1000000, 3'b001, 1'b0, 0, T, 0, 0);
    do_reset();
    issue(MISC, 3'b010, 1'b0, 0, 0, 0, 0);
    issue(7'b1000000, 3'b000, 1'b0, 0, 3, 0, 4);
    do_reset();
    issue(7'h05, 3'd0, 1'b0, T, 0, 0, 0);
    do_reset();
    issue(7'h2A, 3'd0, 1'b0, 0, 0, 0, 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
